paralelo_serial: RTL and testbench



---
 rtl/serial_link_pkg.sv | 9 +
 rtl/ps_shift_reg.sv | 28 ++
 rtl/paralelo_serial.sv | 61 ++++++
 tb/tb_paralelo_serial.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: byte width, comma byte and TX state.
package serial_link_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] COMMA_BC = 8'hBC;

    typedef enum logic {SYNC, ACTIVE} tx_state_t;

endpackage

// File: rtl/ps_shift_reg.sv
// Serializer datapath: loads a byte at a boundary and shifts it out MSB-first.
module ps_shift_reg
    import serial_link_pkg::*;
(
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              load,
    input  logic [BYTE_W-1:0] nb,
    output logic              data_out
);

    logic [BYTE_W-1:0] shreg;

    // The MSB goes straight to data_out on load; shreg holds the remaining bits.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            shreg    <= '0;
            data_out <= 1'b0;
        end else if (load) begin
            data_out <= nb[BYTE_W-1];
            shreg    <= {nb[BYTE_W-2:0], 1'b0};
        end else begin
            data_out <= shreg[BYTE_W-1];
            shreg    <= {shreg[BYTE_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter: sync comma preamble, then data or idle commas.
module paralelo_serial
    import serial_link_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA       = COMMA_BC,
    parameter int unsigned       SYNC_COMMAS = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              active_out
);

    logic [2:0]        bit_cnt;
    logic [3:0]        comma_cnt;
    tx_state_t         state;
    logic              boundary;
    logic [BYTE_W-1:0] nb;

    assign boundary   = (bit_cnt == 3'd7);
    assign ready_out  = boundary && (state == ACTIVE);
    assign active_out = (state == ACTIVE);

    always_comb begin
        nb = COMMA;
        if (state == ACTIVE && valid_in) begin
            nb = data_in;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            bit_cnt   <= 3'd7;
            comma_cnt <= 4'd0;
            state     <= SYNC;
        end else if (boundary) begin
            bit_cnt <= 3'd0;
            if (state == SYNC) begin
                comma_cnt <= comma_cnt + 4'd1;
                // Leave SYNC on the same edge that loads the last preamble comma.
                if (comma_cnt + 4'd1 == 4'(SYNC_COMMAS)) begin
                    state <= ACTIVE;
                end
            end
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    ps_shift_reg u_shift (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .load     (boundary),
        .nb       (nb),
        .data_out (data_out)
    );

endmodule

// File: tb/tb_paralelo_serial.sv
// Self-checking bench: two transmitters (4 and 1 sync commas) against a byte-schedule model.
module tb_paralelo_serial;

    logic       clk_32f = 1'b0;
    logic       reset_a, valid_a, reset_b, valid_b;
    logic [7:0] data_a, data_b;
    logic       ready_a, dout_a, active_a, ready_b, dout_b, active_b;

    int errors = 0;
    int checks = 0;
    int ea = 0, eb = 0;
    logic [7:0] cur_a = 8'h00, cur_b = 8'h00;

    always #5 clk_32f = ~clk_32f;

    paralelo_serial #(.COMMA(8'hBC), .SYNC_COMMAS(4)) dut_a (
        .clk_32f    (clk_32f),
        .reset      (reset_a),
        .data_in    (data_a),
        .valid_in   (valid_a),
        .ready_out  (ready_a),
        .data_out   (dout_a),
        .active_out (active_a)
    );

    paralelo_serial #(.COMMA(8'hBC), .SYNC_COMMAS(1)) dut_b (
        .clk_32f    (clk_32f),
        .reset      (reset_b),
        .data_in    (data_b),
        .valid_in   (valid_b),
        .ready_out  (ready_b),
        .data_out   (dout_b),
        .active_out (active_b)
    );

    // Edge e (1-based since reset release) carries bit (e-1)%8 of byte (e-1)/8.
    // Bytes below sc are commas; later bytes are whatever was offered at their first edge.
    function automatic void model(input logic rst, input logic v, input logic [7:0] d,
                                  input int sc, inout int e, inout logic [7:0] cur,
                                  output logic xd, output logic xa, output logic xr);
        int pos;
        if (rst) begin
            e = 0; cur = 8'h00; xd = 1'b0; xa = 1'b0; xr = 1'b0;
            return;
        end
        e++;
        pos = (e - 1) % 8;
        if (pos == 0) begin
            if ((e - 1) / 8 < sc) cur = 8'hBC;
            else cur = v ? d : 8'hBC;
        end
        xd = cur[7 - pos];
        xa = (e >= 8 * (sc - 1) + 1);
        xr = xa && (e % 8 == 0);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp, input int edge_no);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic tick();
        logic xda, xaa, xra, xdb, xab, xrb;
        @(posedge clk_32f);
        model(reset_a, valid_a, data_a, 4, ea, cur_a, xda, xaa, xra);
        model(reset_b, valid_b, data_b, 1, eb, cur_b, xdb, xab, xrb);
        #1;
        chk("a_data_out",   dout_a,   xda, ea);
        chk("a_active_out", active_a, xaa, ea);
        chk("a_ready_out",  ready_a,  xra, ea);
        chk("b_data_out",   dout_b,   xdb, eb);
        chk("b_active_out", active_b, xab, eb);
        chk("b_ready_out",  ready_b,  xrb, eb);
    endtask

    task automatic rand_b();
        valid_b = 1'($urandom_range(0, 1));
        data_b  = 8'($urandom);
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        data_a  = 8'h00; data_b = 8'h00;

        // Reset held 3 cycles: all outputs low.
        repeat (3) tick();
        reset_a = 1'b0; reset_b = 1'b0;

        // First preamble comma with nothing offered.
        repeat (8) begin rand_b(); tick(); end

        // Valid 0xFF during the rest of SYNC must be ignored.
        valid_a = 1'b1; data_a = 8'hFF;
        repeat (24) begin rand_b(); tick(); end

        // Boundary at edge 33 takes 0x3C; mid-byte inputs are junk and ignored.
        data_a = 8'h3C; valid_a = 1'b1;
        rand_b(); tick();
        repeat (7) begin
            valid_a = 1'b1; data_a = 8'($urandom);
            rand_b(); tick();
        end

        // Edge 41 boundary with valid dropped: idle comma.
        valid_a = 1'b0;
        repeat (8) begin rand_b(); tick(); end

        // Full-rate back-to-back bytes starting with 0x4B, 0xD2.
        for (int i = 0; i < 12; i++) begin
            valid_a = 1'b1;
            data_a  = (i == 0) ? 8'h4B : (i == 1) ? 8'hD2 : 8'($urandom);
            rand_b(); tick();
            repeat (7) begin
                valid_a = 1'($urandom_range(0, 1)); data_a = 8'($urandom);
                rand_b(); tick();
            end
        end

        // Random mix of offered bytes, idles, and COMMA-valued data bytes.
        repeat (160) begin
            valid_a = 1'($urandom_range(0, 1));
            data_a  = ($urandom_range(0, 5) == 0) ? 8'hBC : 8'($urandom);
            rand_b(); tick();
        end

        // Advance to bit_cnt==3 of a byte, then reset mid-byte.
        while (ea % 8 != 4) begin
            valid_a = 1'b1; data_a = 8'($urandom);
            rand_b(); tick();
        end
        reset_a = 1'b1;
        rand_b(); tick();
        rand_b(); tick();
        reset_a = 1'b0;

        // Full preamble again, then some traffic.
        repeat (48) begin
            valid_a = 1'($urandom_range(0, 1)); data_a = 8'($urandom);
            rand_b(); tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
